// File: rtl/adder_arb_pkg.sv
// Shared types and helpers for the shared-adder arbiter slice.
package adder_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_RESP    = 2'd2
  } state_t;

  // Ceiling log2 with a floor of 1, so a 2-requester id is still 1 bit wide.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 31; i++) begin
      if ((32'd1 << i) < v) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/full_adder_2b.sv
// N-bit ripple-carry adder built from a chain of single-bit full adders.
module full_adder_2b #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic c;

  // Ripple the carry from bit 0 upward.
  always_comb begin
    sum = '0;
    c   = cin;
    for (int unsigned i = 0; i < N; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr wins.
module rr_arbiter
  import adder_arb_pkg::*;
#(
  parameter  int unsigned R   = 4,
  localparam int unsigned IDW = clog2(R)
) (
  input  logic [R-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [R-1:0]   gnt,
  output logic [IDW-1:0] gnt_idx
);

  logic        found;
  int unsigned idx;

  // Scan ptr, ptr+1, ... modulo R and grant the first valid requester.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned off = 0; off < R; off++) begin
      idx = (32'(ptr) + off) % R;
      if (en && !found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/adder_share_arbiter.sv
// One ripple adder shared by R requesters under round-robin arbitration;
// one add in flight, result held with its requester id until accepted.
module adder_share_arbiter
  import adder_arb_pkg::*;
#(
  parameter  int unsigned N   = 2,
  parameter  int unsigned R   = 4,
  localparam int unsigned IDW = clog2(R)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [R-1:0]   req_valid,
  output logic [R-1:0]   req_ready,
  input  logic [R*N-1:0] req_a,
  input  logic [R*N-1:0] req_b,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [N-1:0]   rsp_sum,
  output logic           rsp_carry,
  output logic [IDW-1:0] rsp_id
);

  state_t         state, state_next;
  logic [IDW-1:0] rr_ptr;
  logic [N-1:0]   op_a, op_b;
  logic [IDW-1:0] op_id;
  logic [R-1:0]   gnt;
  logic [IDW-1:0] gnt_idx;
  logic           arb_en;
  logic           grant;
  logic [N-1:0]   add_sum;
  logic           add_cout;

  // Gating with rst_n keeps req_ready low while reset is held, even with
  // requests pending, so every output reads zero during reset.
  assign arb_en    = (state == ST_IDLE) && rst_n;
  assign grant     = |gnt;
  assign req_ready = gnt;

  rr_arbiter #(.R(R)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  full_adder_2b #(.N(N)) u_add (
    .a    (op_a),
    .b    (op_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic: IDLE -> COMPUTE -> RESP -> IDLE.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:    if (grant) state_next = ST_COMPUTE;
      ST_COMPUTE: state_next = ST_RESP;
      ST_RESP:    if (rsp_ready) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Operand capture, pointer advance and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_id     <= '0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_carry <= 1'b0;
      rsp_id    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (grant) begin
            op_a   <= req_a[32'(gnt_idx)*N +: N];
            op_b   <= req_b[32'(gnt_idx)*N +: N];
            op_id  <= gnt_idx;
            rr_ptr <= (32'(gnt_idx) == R - 1) ? '0 : gnt_idx + 1'b1;
          end
        end
        ST_COMPUTE: begin
          rsp_sum   <= add_sum;
          rsp_carry <= add_cout;
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
        end
        ST_RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter (N=2, R=4) against a
// behavioural round-robin / arithmetic reference model.
module tb_adder_share_arbiter;

  localparam int unsigned N   = 2;
  localparam int unsigned R   = 4;
  localparam int unsigned IDW = 2;

  logic           clk;
  logic           rst_n;
  logic [R-1:0]   req_valid;
  logic [R-1:0]   req_ready;
  logic [R*N-1:0] req_a;
  logic [R*N-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [N-1:0]   rsp_sum;
  logic           rsp_carry;
  logic [IDW-1:0] rsp_id;

  int checks;
  int errors;
  int mptr;   // model round-robin pointer

  adder_share_arbiter #(.N(N), .R(R)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .rsp_id    (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: present mask/operands, check the grant, the result
  // and its stability for 'hold' stalled cycles, then accept it.
  task automatic do_txn(input logic [R-1:0] mask, input logic [R*N-1:0] a,
                        input logic [R*N-1:0] b, input int hold, output int id_obs);
    int win, ea, eb, es;
    logic [N-1:0] s0;
    logic c0;
    logic [IDW-1:0] i0;
    win = -1;
    for (int off = 0; off < R; off++) begin
      if (win < 0 && mask[(mptr + off) % R]) win = (mptr + off) % R;
    end
    ea = int'(a[win*N +: N]);
    eb = int'(b[win*N +: N]);
    es = ea + eb;
    req_valid = mask;
    req_a     = a;
    req_b     = b;
    rsp_ready = 1'b0;
    #1;
    check("grant", 32'(req_ready), 32'(1 << win));
    tick();
    mptr = (win + 1) % R;
    req_valid = '0;
    #1;
    check("compute_valid", 32'(rsp_valid), 0);
    check("compute_ready", 32'(req_ready), 0);
    tick();
    check("rsp_valid", 32'(rsp_valid), 1);
    check("rsp_sum", 32'(rsp_sum), 32'(es % (1 << N)));
    check("rsp_carry", 32'(rsp_carry), 32'(es >> N));
    check("rsp_id", 32'(rsp_id), 32'(win));
    s0 = rsp_sum; c0 = rsp_carry; i0 = rsp_id;
    id_obs = int'(rsp_id);
    req_valid = mask;
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", 32'(rsp_valid), 1);
      check("hold_stable", {rsp_sum, rsp_carry, rsp_id}, {s0, c0, i0});
      check("hold_ready", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    tick();
    rsp_ready = 1'b0;
    check("accept_clear", 32'(rsp_valid), 0);
  endtask

  initial begin
    int id;
    logic [R*N-1:0] ra, rb;
    checks = 0;
    errors = 0;
    mptr = 0;
    rst_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    check("reset_outputs", {rsp_valid, rsp_sum, rsp_carry, rsp_id, req_ready}, '0);
    rst_n = 1'b1;
    tick();

    // Single requester 2: 3 + 1 -> sum 0, carry 1.
    ra = '0; rb = '0;
    ra[2*N +: N] = 2'd3;
    rb[2*N +: N] = 2'd1;
    do_txn(4'b0100, ra, rb, 0, id);
    check("single_id", 32'(id), 2);

    // Reset during COMPUTE: transaction dropped, outputs clear at once.
    req_valid = 4'b1000;
    req_a = '1; req_b = '1;
    tick();
    req_valid = '0;
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset", {rsp_valid, rsp_sum, rsp_carry, rsp_id, req_ready}, '0);
    tick();
    rst_n = 1'b1;
    mptr = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("dropped_no_rsp", 32'(rsp_valid), 0);
    end
    req_valid = 4'b1010;
    #1;
    check("post_reset_lowest", 32'(req_ready), 32'b0010);
    req_valid = '0;

    // All four valid: grant order 0,1,2,3,0 after the pointer restart.
    mptr = 0;
    for (int i = 0; i < 5; i++) begin
      ra = 8'hE4; rb = 8'h1B;
      do_txn(4'b1111, ra, rb, (i == 2) ? 5 : 0, id);
      check("rr_order", 32'(id), 32'(i % R));
    end

    // Exhaustive operand sweep through requester 1.
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        ra = '0; rb = '0;
        ra[1*N +: N] = 2'(a);
        rb[1*N +: N] = 2'(b);
        do_txn(4'b0010, ra, rb, 0, id);
      end
    end

    // Random masks, operands and consumer stalls.
    for (int t = 0; t < 40; t++) begin
      logic [R-1:0] m;
      m = 4'($urandom_range(1, 15));
      ra = 8'($urandom);
      rb = 8'($urandom);
      do_txn(m, ra, rb, int'($urandom_range(0, 3)), id);
    end

    // rsp_ready while idle must have no effect.
    rsp_ready = 1'b1;
    tick();
    tick();
    rsp_ready = 1'b0;
    check("idle_ready_ignored", 32'(rsp_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
